fetch_seq: RTL and testbench
============================

// Module: fetch_seq
// PURPOSE
//   Instruction-fetch sequencer for the 16-bit CPU; replaces the free-running address generator in front of cpurom.
//   Drives the ROM address so the synchronous ROM output is the instruction at pc_out every valid cycle.
//   Supports start, stall, taken branch/jump and a HALT opcode. Counts retired instructions.
//   Sits between cpurom and the decode/execute stage.
// PARAMETERS
//   AW       8      ROM address width; the PC width
//   DW       16     instruction width
//   HALT_OP  4'hF   opcode in instr[15:12] that stops fetch
//   CW       16     width of the retired-instruction counter
// PORTS
//   clk          in   1   rising-edge clock; the same clock drives cpurom
//   rst          in   1   asynchronous reset, active-high
//   start        in   1   level or pulse; leaves IDLE/HALT and fetches from address 0
//   stall        in   1   holds the current instruction; nothing retires
//   br_take      in   1   redirect fetch to br_target; valid only when instr_valid=1
//   br_target    in   AW  branch/jump destination address
//   rom_q        in   DW  cpurom q: the word at the rom_addr sampled at the previous edge
//   rom_addr     out  AW  cpurom address (combinational)
//   instr        out  DW  current instruction; equals rom_q
//   instr_valid  out  1   instr is valid and belongs to pc_out (registered)
//   pc_out       out  AW  address of instr (registered)
//   halted       out  1   the HALT opcode has been executed (registered)
//   icount       out  CW  number of instructions retired since the last start (registered)
// BEHAVIOUR
//   Reset (asynchronous; takes effect immediately, including mid-run):
//     state=IDLE; pc_out=0; instr_valid=0; halted=0; icount=0; rom_addr evaluates to 0.
//   Timing:
//     cpurom registers its address at each clk edge.
//     At every edge, pc_out <= rom_addr, so rom_q = ROM[pc_out] in the next cycle.
//     This gives zero-bubble sequencing.
//   States (2-bit): IDLE, RUN, HALT.
//   IDLE:
//     rom_addr=0; instr_valid=0.
//     start=1 -> RUN at the next edge: pc_out<=0, instr_valid<=1, icount<=0.
//   RUN: instr_valid=1. rom_addr priority is:
//     1. stall=1                          -> pc_out (re-read; no retire; icount holds)
//     2. rom_q[15:12]==HALT_OP            -> pc_out, and the next state is HALT
//     3. br_take=1                        -> br_target
//     4. otherwise                        -> pc_out+1 (mod 2^AW; 0xFF wraps to 0x00 with no flag)
//     Retire occurs when state==RUN and stall=0, including the HALT instruction.
//     On retire, icount increments and saturates at all-ones.
//     If stall and HALT_OP occur together, the block stays in RUN and HALT is taken when stall drops.
//     If br_take and HALT_OP occur together, HALT wins and the branch is ignored.
//     start is ignored in RUN.
//   HALT:
//     On entry: instr_valid<=0, halted<=1; pc_out holds the HALT address; icount holds.
//     rom_addr=0.
//     start=1 -> RUN at the next edge: pc_out<=0, instr_valid<=1, halted<=0, icount<=0.
//   Inputs are ignored outside RUN: stall, br_take, br_target.
//   No latches. rom_addr is the only combinational output apart from instr.
// TESTING
//   T1 Reset, start pulse at cycle 2, ROM filled with NOPs (op 0)
//      -> instr_valid=1 from cycle 3; pc_out 0,1,2,...; rom_addr=pc_out+1; icount increments every cycle.
//   T2 stall=1 for 3 cycles while pc_out=5
//      -> rom_addr=5, pc_out=5, icount frozen; pc_out=6 on the first cycle after stall drops.
//   T3 br_take=1, br_target=8'h40 at pc_out=3
//      -> next cycle pc_out=8'h40 and instr=ROM[0x40] with no bubble.
//      -> br_take with instr_valid=0 (IDLE) has no effect.
//   T4 ROM[7]=16'hF000, straight-line code from 0
//      -> after pc_out=7: halted=1, instr_valid=0, icount=8, pc_out=7.
//      -> start then gives pc_out=0, halted=0, icount restarting from 0.
//   T5 br_target=8'hFE, ROM[FE..FF] = NOP
//      -> pc_out sequence FE, FF, 00, 01; wrap is silent.
//   T6 rst=1 asynchronously mid-cycle at pc_out=8'h20
//      -> immediately pc_out=0, instr_valid=0, halted=0, icount=0, rom_addr=0; state IDLE until start.

Source files
------------

// File: rtl/fetch_seq_if.sv
// Fetch sequencer bus: control inputs, ROM port and fetched-instruction outputs.
// master: the fetch sequencer; slave: the CPU/ROM side.
interface fetch_seq_if #(
    parameter int AW = 8,
    parameter int DW = 16,
    parameter int CW = 16
);
    logic          start;
    logic          stall;
    logic          br_take;
    logic [AW-1:0] br_target;
    logic [DW-1:0] rom_q;
    logic [AW-1:0] rom_addr;
    logic [DW-1:0] instr;
    logic          instr_valid;
    logic [AW-1:0] pc_out;
    logic          halted;
    logic [CW-1:0] icount;

    modport master (
        input  start, stall, br_take, br_target, rom_q,
        output rom_addr, instr, instr_valid, pc_out, halted, icount
    );

    modport slave (
        output start, stall, br_take, br_target, rom_q,
        input  rom_addr, instr, instr_valid, pc_out, halted, icount
    );
endinterface

// File: rtl/fetch_seq.sv
// Instruction-fetch sequencer in front of a synchronous ROM.
// rom_addr is the address presented to the ROM this cycle, so it also becomes
// pc_out at the next edge, which keeps rom_q aligned with pc_out (no bubbles).
module fetch_seq #(
    parameter int         AW      = 8,
    parameter int         DW      = 16,
    parameter logic [3:0] HALT_OP = 4'hF,
    parameter int         CW      = 16
) (
    input logic         clk,
    input logic         rst,
    fetch_seq_if.master bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [AW-1:0] addr_nxt;
    logic          retire;
    logic [3:0]    opcode;

    assign opcode       = bus.rom_q[DW-1 -: 4];
    assign bus.rom_addr = addr_nxt;
    assign bus.instr    = bus.rom_q;

    // Next state, next fetch address and retire decision
    always_comb begin
        state_nxt = state;
        addr_nxt  = '0;
        retire    = 1'b0;
        case (state)
            RUN: begin
                if (bus.stall) begin
                    addr_nxt = bus.pc_out;
                end else begin
                    retire = 1'b1;
                    if (opcode == HALT_OP) begin
                        addr_nxt  = bus.pc_out;
                        state_nxt = HALT;
                    end else if (bus.br_take) begin
                        addr_nxt = bus.br_target;
                    end else begin
                        addr_nxt = bus.pc_out + AW'(1);
                    end
                end
            end
            IDLE, HALT: begin
                if (bus.start) begin
                    state_nxt = RUN;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // State register, PC tracking, status flags and saturating retire counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= IDLE;
            bus.pc_out      <= '0;
            bus.instr_valid <= 1'b0;
            bus.halted      <= 1'b0;
            bus.icount      <= '0;
        end else begin
            state           <= state_nxt;
            bus.instr_valid <= (state_nxt == RUN);
            bus.halted      <= (state_nxt == HALT);
            // pc_out follows rom_addr except while sitting in HALT, where
            // rom_addr is parked at 0 but pc_out must keep the HALT address.
            if (state_nxt != HALT) begin
                bus.pc_out <= addr_nxt;
            end
            if (state != RUN && state_nxt == RUN) begin
                bus.icount <= '0;
            end else if (retire && bus.icount != '1) begin
                bus.icount <= bus.icount + CW'(1);
            end
        end
    end

endmodule

// File: tb/tb_fetch_seq.sv
// Self-checking bench for fetch_seq: behavioural ROM, reference model feeding
// a scoreboard queue, plus directed checks at the interesting boundaries.
module tb_fetch_seq;
    localparam int AW = 8;
    localparam int DW = 16;
    localparam int CW = 16;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fetch_seq_if #(.AW(AW), .DW(DW), .CW(CW)) bus ();

    fetch_seq #(.AW(AW), .DW(DW), .HALT_OP(4'hF), .CW(CW)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    // Synchronous ROM model (cpurom)
    logic [DW-1:0] rom [256];
    always @(posedge clk) bus.rom_q <= rom[bus.rom_addr];

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    typedef enum {M_IDLE, M_RUN, M_HALT} mstate_t;
    typedef struct {
        logic [7:0]  pc;
        logic        valid;
        logic        halted;
        logic [15:0] cnt;
    } exp_t;

    mstate_t     m_st;
    logic [7:0]  m_pc;
    logic        m_valid;
    logic        m_halt;
    logic [15:0] m_cnt;
    exp_t        sb[$];

    task automatic model_reset();
        m_st = M_IDLE; m_pc = '0; m_valid = 1'b0; m_halt = 1'b0; m_cnt = '0;
        sb.delete();
    endtask

    // One clock: predict before the edge, compare after it.
    task automatic cycle();
        logic [7:0] a;
        exp_t       e;
        exp_t       g;
        @(negedge clk);
        a = '0;
        if (m_st == M_RUN) begin
            if (bus.stall) begin
                a = m_pc;
            end else begin
                if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
                if (rom[m_pc][15:12] == 4'hF) begin
                    a = m_pc; m_st = M_HALT; m_valid = 1'b0; m_halt = 1'b1;
                end else if (bus.br_take) begin
                    a = bus.br_target;
                end else begin
                    a = m_pc + 8'd1;
                end
            end
            m_pc = a;
        end else if (bus.start) begin
            m_st = M_RUN; m_pc = '0; m_valid = 1'b1; m_halt = 1'b0; m_cnt = '0;
        end
        check("rom_addr", 32'(bus.rom_addr), 32'(a));
        e.pc = m_pc; e.valid = m_valid; e.halted = m_halt; e.cnt = m_cnt;
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            check("sb_empty", 32'(1), 32'(0));
        end else begin
            g = sb.pop_front();
            check("pc_out", 32'(bus.pc_out), 32'(g.pc));
            check("instr_valid", 32'(bus.instr_valid), 32'(g.valid));
            check("halted", 32'(bus.halted), 32'(g.halted));
            check("icount", 32'(bus.icount), 32'(g.cnt));
            if (g.valid) check("instr", 32'(bus.instr), 32'(rom[g.pc]));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 256; i++) rom[i] = 16'(i);
        rom[7] = 16'hF000;
        bus.start = 1'b0; bus.stall = 1'b0; bus.br_take = 1'b0; bus.br_target = '0;
        model_reset();
        rst = 1'b1;
        #12;
        check("rst_pc", 32'(bus.pc_out), 32'(0));
        check("rst_valid", 32'(bus.instr_valid), 32'(0));
        check("rst_halted", 32'(bus.halted), 32'(0));
        check("rst_icount", 32'(bus.icount), 32'(0));
        check("rst_addr", 32'(bus.rom_addr), 32'(0));
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;

        // Branch request while idle must be ignored
        bus.br_take = 1'b1; bus.br_target = 8'h40;
        cycle(); cycle();
        bus.br_take = 1'b0;

        // Start, then straight-line to the HALT at address 7
        bus.start = 1'b1; cycle(); bus.start = 1'b0;
        cycle(); cycle();
        bus.start = 1'b1; cycle(); bus.start = 1'b0;   // ignored in RUN
        for (int i = 0; i < 12 && m_pc != 8'd7; i++) cycle();
        check("reach_pc7", 32'(bus.pc_out), 32'(7));
        bus.stall = 1'b1; cycle(); bus.stall = 1'b0;   // stall defers the HALT
        bus.br_take = 1'b1; bus.br_target = 8'h40; cycle(); bus.br_take = 1'b0; // HALT beats branch
        check("halt_halted", 32'(bus.halted), 32'(1));
        check("halt_valid", 32'(bus.instr_valid), 32'(0));
        check("halt_icount", 32'(bus.icount), 32'(8));
        check("halt_pc", 32'(bus.pc_out), 32'(7));
        cycle();

        // Restart from HALT
        bus.start = 1'b1; cycle(); bus.start = 1'b0;
        check("restart_pc", 32'(bus.pc_out), 32'(0));
        check("restart_icount", 32'(bus.icount), 32'(0));
        cycle(); cycle(); cycle();
        bus.br_take = 1'b1; bus.br_target = 8'h40; cycle(); bus.br_take = 1'b0;
        check("branch_pc", 32'(bus.pc_out), 32'(8'h40));
        cycle();
        bus.br_take = 1'b1; bus.br_target = 8'h05; cycle(); bus.br_take = 1'b0;
        bus.stall = 1'b1; cycle(); cycle(); cycle(); bus.stall = 1'b0;
        check("stall_pc", 32'(bus.pc_out), 32'(5));
        check("stall_icount", 32'(bus.icount), 32'(6));
        cycle();
        check("post_stall_pc", 32'(bus.pc_out), 32'(6));

        // Wrap FE, FF, 00, 01
        bus.br_take = 1'b1; bus.br_target = 8'hFE; cycle(); bus.br_take = 1'b0;
        cycle(); cycle();
        check("wrap_pc0", 32'(bus.pc_out), 32'(0));
        cycle();
        check("wrap_pc1", 32'(bus.pc_out), 32'(1));

        // Run to 0x20 then reset asynchronously mid-cycle
        bus.br_take = 1'b1; bus.br_target = 8'h1E; cycle(); bus.br_take = 1'b0;
        cycle(); cycle();
        check("pre_rst_pc", 32'(bus.pc_out), 32'(8'h20));
        #3 rst = 1'b1;
        #1;
        model_reset();
        check("arst_pc", 32'(bus.pc_out), 32'(0));
        check("arst_valid", 32'(bus.instr_valid), 32'(0));
        check("arst_halted", 32'(bus.halted), 32'(0));
        check("arst_icount", 32'(bus.icount), 32'(0));
        check("arst_addr", 32'(bus.rom_addr), 32'(0));
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
        cycle(); cycle();
        bus.start = 1'b1; cycle(); bus.start = 1'b0;
        cycle(); cycle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
